instr_prefetch_buffer: RTL and testbench

Word-aligned instruction prefetcher that sits directly upstream of the fetch stage. It issues requests to instruction memory over a req/gnt/rvalid handshake and tracks outstanding transactions. Responses are buffered in a small FIFO and handed to the fetch stage on a valid/ready interface with the word's address and error flag. On a redirect it flushes buffered words and discards responses still in flight.

---
 rtl/instr_prefetch_buffer.sv | 163 ++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Word-aligned instruction prefetcher: issues req/gnt/rvalid fetches, buffers
// responses in a small FIFO for the fetch stage and flushes on redirect.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] boot_addr_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DW = $clog2(MAX_OUTSTANDING + 2);

  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   resp_addr_q, resp_addr_d;
  logic [31:0]   tgt_addr_q, tgt_addr_d;
  logic          tgt_pend_q, tgt_pend_d;
  logic          pend_q, pend_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [DW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;

  logic [31:0]   fifo_rdata_q [DEPTH];
  logic [31:0]   fifo_addr_q  [DEPTH];
  logic          fifo_err_q   [DEPTH];

  logic [31:0]   boot_fetch;
  logic [31:0]   branch_target;
  logic          credit_ok;
  logic          grant;
  logic          push;
  logic          pop;
  logic          unused_bits;

  assign boot_fetch    = {boot_addr_i[31:8], 8'h80};
  assign branch_target = {branch_addr_i[31:2], 2'b00};
  assign unused_bits   = ^{boot_addr_i[7:0], branch_addr_i[1:0]};

  // Count responses in flight against FIFO space so a push can never overflow.
  assign credit_ok    = (32'(outst_q) < MAX_OUTSTANDING) &&
                        ((32'(count_q) + 32'(outst_q)) < DEPTH);
  assign instr_req_o  = pend_q | (req_i & ~branch_i & credit_ok);
  assign instr_addr_o = fetch_addr_q;
  assign grant        = instr_req_o & instr_gnt_i;
  assign push         = instr_rvalid_i & ~branch_i & (discard_q == '0);
  assign valid_o      = (count_q != '0) & ~branch_i;
  assign pop          = valid_o & ready_i;
  assign busy_o       = (outst_q != '0) | instr_req_o;

  assign rdata_o = fifo_rdata_q[rd_ptr_q];
  assign addr_o  = fifo_addr_q[rd_ptr_q];
  assign err_o   = fifo_err_q[rd_ptr_q];

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_addr_d  = resp_addr_q;
    tgt_addr_d   = tgt_addr_q;
    tgt_pend_d   = tgt_pend_q;
    pend_d       = pend_q;
    outst_d      = outst_q + OW'(grant) - OW'(instr_rvalid_i);
    discard_d    = discard_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    if (grant) begin
      pend_d       = 1'b0;
      tgt_pend_d   = 1'b0;
      fetch_addr_d = tgt_pend_q ? tgt_addr_q : fetch_addr_q + 32'd4;
    end else if (instr_req_o) begin
      pend_d = 1'b1;
    end

    if (branch_i) begin
      count_d     = '0;
      resp_addr_d = branch_target;
      // Everything still in flight, including a request stuck waiting for gnt, is stale.
      discard_d   = DW'(outst_q) - DW'(instr_rvalid_i) + DW'(pend_q);
      if (pend_q && !instr_gnt_i) begin
        tgt_pend_d = 1'b1;
        tgt_addr_d = branch_target;
      end else begin
        tgt_pend_d   = 1'b0;
        fetch_addr_d = branch_target;
      end
    end else begin
      if (instr_rvalid_i && (discard_q != '0)) begin
        discard_d = discard_q - DW'(1);
      end
      if (push) begin
        resp_addr_d = resp_addr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr_q <= boot_fetch;
      resp_addr_q  <= boot_fetch;
      tgt_addr_q   <= '0;
      tgt_pend_q   <= 1'b0;
      pend_q       <= 1'b0;
      outst_q      <= '0;
      discard_q    <= '0;
      count_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
      tgt_addr_q   <= tgt_addr_d;
      tgt_pend_q   <= tgt_pend_d;
      pend_q       <= pend_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || branch_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        fifo_rdata_q[gi] <= '0;
        fifo_addr_q[gi]  <= '0;
        fifo_err_q[gi]   <= 1'b0;
      end else if (push && (wr_ptr_q == PW'(gi))) begin
        fifo_rdata_q[gi] <= instr_rdata_i;
        fifo_addr_q[gi]  <= resp_addr_q;
        fifo_err_q[gi]   <= instr_err_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: a randomised memory responder plus a
// fetch-stage model that expects a contiguous word stream from each redirect.
module tb_instr_prefetch_buffer;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] boot_addr_i;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        busy_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .boot_addr_i(boot_addr_i), .req_i(req_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i), .ready_i(ready_i),
    .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int due; } rsp_t;
  rsp_t        mq[$];
  logic [31:0] gq[$];

  int tests = 0, fails = 0, cyc = 0;
  int gnt_pct = 100, rv_pct = 100, lat_extra = 0;
  int npop = 0, first_gnt = -1, first_valid = -1, n0 = 0;
  bit hold_q = 0, rand_err = 0, cap_first = 0;
  logic [31:0] exp_addr = 0, hold_addr = 0, err_addr = 32'h0000_1088, first_pop = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_addr) || (rand_err && (a[6:2] == 5'b10110));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: memory reacts, fetch-stage model checks, then the edge.
  task automatic step();
    int outs;
    outs = mq.size();
    #1;
    instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rdata_i  = '0;   instr_err_i = 1'b0;
    if (!rst_n) begin
      mq.delete();
      hold_q   = 0;
      exp_addr = {boot_addr_i[31:8], 8'h80};
    end else begin
      if (mq.size() != 0 && mq[0].due <= cyc && int'($urandom_range(99)) < rv_pct) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_data(mq[0].a);
        instr_err_i    = mem_err(mq[0].a);
        void'(mq.pop_front());
      end
      if (instr_req_o && int'($urandom_range(99)) < gnt_pct) begin
        instr_gnt_i = 1'b1;
        mq.push_back('{a: instr_addr_o, due: cyc + 1 + int'($urandom_range(lat_extra, 0))});
        gq.push_back(instr_addr_o);
        if (first_gnt < 0) first_gnt = cyc;
      end
    end
    #1;
    if (rst_n) begin
      chk("busy", 32'(busy_o), 32'(outs != 0 || instr_req_o));
      chk("credit", 32'(instr_req_o && !hold_q && outs >= MAXO), 32'd0);
      if (hold_q) begin
        chk("req_hold", 32'(instr_req_o), 32'd1);
        chk("addr_hold", instr_addr_o, hold_addr);
      end
      if (valid_o && first_valid < 0) first_valid = cyc;
      if (branch_i) begin
        chk("valid_in_branch", 32'(valid_o), 32'd0);
        exp_addr = {branch_addr_i[31:2], 2'b00};
      end else if (valid_o && ready_i) begin
        chk("pop_addr", addr_o, exp_addr);
        chk("pop_data", rdata_o, mem_data(exp_addr));
        chk("pop_err", 32'(err_o), 32'(mem_err(exp_addr)));
        if (cap_first) begin first_pop = addr_o; cap_first = 0; end
        exp_addr = exp_addr + 32'd4;
        npop++;
      end
      hold_q    = instr_req_o && !instr_gnt_i;
      hold_addr = instr_addr_o;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; boot_addr_i = 32'h0000_1000; req_i = 1'b0; branch_i = 1'b0;
    branch_addr_i = '0; ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    @(negedge clk);
    step(); step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_fetch", instr_addr_o, 32'h0000_1080);

    // Boot sequence, zero-wait memory, error word at 0x1088.
    rst_n = 1'b1; req_i = 1'b1; ready_i = 1'b1;
    gq.delete(); first_gnt = -1; first_valid = -1; npop = 0;
    for (int i = 0; i < 12; i++) step();
    chk("boot_a0", gq[0], 32'h1080);
    chk("boot_a1", gq[1], 32'h1084);
    chk("boot_a2", gq[2], 32'h1088);
    chk("after_err_a3", gq[3], 32'h108C);
    chk("first_valid_lat", 32'(first_valid - first_gnt), 32'd2);
    chk("throughput", 32'(npop), 32'd10);
    err_addr = 32'hFFFF_FFFF;

    // Backpressure fills the FIFO, then drains in order.
    ready_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("full_valid", 32'(valid_o), 32'd1);
    chk("full_req", 32'(instr_req_o), 32'd0);
    chk("full_busy", 32'(busy_o), 32'd0);
    ready_i = 1'b1; req_i = 1'b0; n0 = npop;
    for (int i = 0; i < 6; i++) step();
    chk("drain_count", 32'(npop - n0), 32'd4);
    chk("drain_empty", 32'(valid_o), 32'd0);

    // Redirect with two responses in flight.
    req_i = 1'b1; rv_pct = 0;
    for (int i = 0; i < 3; i++) step();
    chk("outst_cap_req", 32'(instr_req_o), 32'd0);
    chk("outst_busy", 32'(busy_o), 32'd1);
    branch_i = 1'b1; branch_addr_i = 32'h0000_2006; cap_first = 1;
    step();
    branch_i = 1'b0; rv_pct = 100;
    for (int i = 0; i < 8; i++) step();
    chk("br_first_word", first_pop, 32'h0000_2004);

    // Redirect in steady stream: coincident rvalid and pop are dropped.
    n0 = npop;
    branch_i = 1'b1; branch_addr_i = 32'h0000_4000;
    step();
    chk("br_no_pop", 32'(npop - n0), 32'd0);
    branch_i = 1'b0;
    #1;
    chk("br1_req", 32'(instr_req_o), 32'd1);
    chk("br1_addr", instr_addr_o, 32'h0000_4000);
    chk("br1_empty", 32'(valid_o), 32'd0);
    step();
    chk("br2_valid", 32'(valid_o), 32'd0);
    step();
    chk("br3_valid", 32'(valid_o), 32'd1);
    chk("br3_addr", addr_o, 32'h0000_4000);

    // Quiesce, then redirect while a request waits for its grant.
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    branch_i = 1'b1; branch_addr_i = 32'h0000_5000;
    step();
    branch_i = 1'b0;
    step(); step();
    gq.delete(); gnt_pct = 0; req_i = 1'b1; n0 = npop;
    step();
    branch_i = 1'b1; branch_addr_i = 32'h0000_0300;
    step();
    branch_i = 1'b0; req_i = 1'b0;
    step();
    gnt_pct = 100; req_i = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("pend_gnt_addr", gq[0], 32'h0000_5000);
    chk("pend_next_req", gq[1], 32'h0000_0300);
    chk("pend_progress", 32'(npop > n0), 32'd1);

    // Randomised traffic with one mid-run reset.
    gnt_pct = 60; rv_pct = 70; lat_extra = 3; rand_err = 1; n0 = npop;
    for (int i = 0; i < 3000; i++) begin
      req_i         = (int'($urandom_range(99)) < 90);
      ready_i       = (int'($urandom_range(99)) < 70);
      branch_i      = (int'($urandom_range(99)) < 3);
      branch_addr_i = $urandom();
      rst_n         = (i != 1500);
      if (i == 1500) boot_addr_i = $urandom();
      step();
      if (i == 1500) begin
        rst_n = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_fetch", instr_addr_o, {boot_addr_i[31:8], 8'h80});
      end
    end
    chk("rand_progress", 32'(npop - n0 > 300), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
